// File: rtl/scroll_controller_if.sv
// Board-side bundle for the scroll controller: raw key/switch inputs and display-side outputs.
interface scroll_controller_if #(
    parameter int POS_W = 3
);
    logic [1:0]       key_n;
    logic             mode_sw;
    logic             dir_sw;
    logic [POS_W-1:0] pos;
    logic             step;
    logic [1:0]       state;

    modport master (output key_n, mode_sw, dir_sw, input pos, step, state);
    modport slave  (input key_n, mode_sw, dir_sw, output pos, step, state);
endinterface

// File: rtl/scroll_controller.sv
// Position sequencer for the rotating word display: sync, debounce, manual/auto/paused FSM.
// Optional SCROLL_BOUNCE_EN makes AUTO ping-pong between the end positions instead of wrapping.
module scroll_controller #(
    parameter int NUM_POS         = 6,
    parameter int POS_W           = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TICK_DIV        = 25000000
) (
    input  logic               clk,
    input  logic               reset,
    scroll_controller_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(NUM_POS - 1);

    typedef enum logic [1:0] {
        ST_MANUAL = 2'b00,
        ST_AUTO   = 2'b01,
        ST_PAUSED = 2'b10
    } state_t;

    logic [1:0]         key_s1_q, key_s2_q, key_deb_q, key_prev_q;
    logic [1:0][DW-1:0] deb_cnt_q;
    logic               mode_s1_q, mode_s2_q, dir_s1_q, dir_s2_q;
    logic [1:0]         press;
    logic               lev, rev;

    state_t           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d, auto_pos;
    logic [PW-1:0]    presc_q, presc_d;
    logic             step_q, step_d;
    logic             tick;

`ifdef SCROLL_BOUNCE_EN
    logic dir_dn_q, dir_dn_d;
    logic bounce_up;
`endif

    function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
        return (p == POS_MAX) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [POS_W-1:0] pos_dec(input logic [POS_W-1:0] p);
        return (p == '0) ? POS_MAX : p - 1'b1;
    endfunction

    // Input synchronisers and per-key debounce; a level is accepted after DEBOUNCE_CYCLES stable samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_s1_q   <= 2'b11;
            key_s2_q   <= 2'b11;
            key_deb_q  <= 2'b11;
            key_prev_q <= 2'b11;
            deb_cnt_q  <= '0;
            mode_s1_q  <= 1'b0;
            mode_s2_q  <= 1'b0;
            dir_s1_q   <= 1'b0;
            dir_s2_q   <= 1'b0;
        end else begin
            key_s1_q   <= bus.key_n;
            key_s2_q   <= key_s1_q;
            mode_s1_q  <= bus.mode_sw;
            mode_s2_q  <= mode_s1_q;
            dir_s1_q   <= bus.dir_sw;
            dir_s2_q   <= dir_s1_q;
            key_prev_q <= key_deb_q;
            for (int k = 0; k < 2; k++) begin
                if (key_s2_q[k] == key_deb_q[k]) begin
                    deb_cnt_q[k] <= '0;
                end else if (deb_cnt_q[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    key_deb_q[k] <= key_s2_q[k];
                    deb_cnt_q[k] <= '0;
                end else begin
                    deb_cnt_q[k] <= deb_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign press = key_prev_q & ~key_deb_q;
    assign lev   = press[1];
    assign rev   = press[0];
    assign tick  = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
`ifdef SCROLL_BOUNCE_EN
        bounce_up = ~dir_dn_q;
        if (bounce_up && pos_q == POS_MAX) begin
            bounce_up = 1'b0;
        end else if (!bounce_up && pos_q == '0) begin
            bounce_up = 1'b1;
        end
        auto_pos = bounce_up ? pos_inc(pos_q) : pos_dec(pos_q);
`else
        auto_pos = dir_s2_q ? pos_dec(pos_q) : pos_inc(pos_q);
`endif
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        presc_d = presc_q;
        step_d  = 1'b0;
`ifdef SCROLL_BOUNCE_EN
        dir_dn_d = dir_dn_q;
`endif
        if (lev && rev) begin
            pos_d   = '0;
            step_d  = 1'b1;
            presc_d = '0;
        end else begin
            unique case (state_q)
                ST_MANUAL: begin
                    if (mode_s2_q) begin
                        state_d = ST_AUTO;
                        presc_d = '0;
`ifdef SCROLL_BOUNCE_EN
                        dir_dn_d = dir_s2_q;
`endif
                    end else if (lev) begin
                        pos_d  = pos_inc(pos_q);
                        step_d = 1'b1;
                    end else if (rev) begin
                        pos_d  = pos_dec(pos_q);
                        step_d = 1'b1;
                    end
                end
                ST_AUTO: begin
                    if (!mode_s2_q) begin
                        state_d = ST_MANUAL;
                        presc_d = '0;
                    end else if (lev || rev) begin
                        state_d = ST_PAUSED;
                    end else if (tick) begin
                        presc_d = '0;
                        pos_d   = auto_pos;
                        step_d  = 1'b1;
`ifdef SCROLL_BOUNCE_EN
                        dir_dn_d = ~bounce_up;
`endif
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (!mode_s2_q) begin
                        state_d = ST_MANUAL;
                        presc_d = '0;
                    end else if (lev || rev) begin
                        state_d = ST_AUTO;
                        presc_d = '0;
`ifdef SCROLL_BOUNCE_EN
                        dir_dn_d = dir_s2_q;
`endif
                    end
                end
                default: state_d = ST_MANUAL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_MANUAL;
            pos_q   <= '0;
            presc_q <= '0;
            step_q  <= 1'b0;
`ifdef SCROLL_BOUNCE_EN
            dir_dn_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            presc_q <= presc_d;
            step_q  <= step_d;
`ifdef SCROLL_BOUNCE_EN
            dir_dn_q <= dir_dn_d;
`endif
        end
    end

    assign bus.pos   = pos_q;
    assign bus.step  = step_q;
    assign bus.state = state_q;
endmodule

// File: tb/tb_scroll_controller.sv
// Bench for scroll_controller: vector table for manual stepping, scripted auto/pause/reset cases,
// and a step-pulse scoreboard holding every expected position.
module tb_scroll_controller;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   exp_q[$];
    int   seq_a[$];
    int   seq_b[$];

    scroll_controller_if #(.POS_W(3)) bus ();

    scroll_controller #(
        .NUM_POS(6), .POS_W(3), .DEBOUNCE_CYCLES(4), .TICK_DIV(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [1:0] key_n;
        int         hold;
        int         push;
        int         pos;
    } vec_t;

    vec_t vecs[28];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] k, input int h, input int p, input int e);
        vec_t v;
        v.key_n = k;
        v.hold  = h;
        v.push  = p;
        v.pos   = e;
        return v;
    endfunction

    // Every step pulse must match the oldest expected position.
    always @(negedge clk) begin
        if (bus.step === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_step: got step at pos %0d expected no step", bus.pos);
            end else begin
                check("sb_step_pos", 32'(bus.pos), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic run_auto(input logic dir, input int n);
        bus.mode_sw = 1'b1;
        bus.dir_sw  = dir;
        cyc(3 + 8 * n + 1);
        bus.mode_sw = 1'b0;
        cyc(6);
        check("auto_run_exit_state", 32'(bus.state), 32'd0);
        check("auto_run_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.key_n   = 2'b11;
        bus.mode_sw = 1'b0;
        bus.dir_sw  = 1'b0;
        cyc(3);
        reset = 1'b0;
        check("reset_pos", 32'(bus.pos), 32'd0);
        check("reset_step", 32'(bus.step), 32'd0);
        check("reset_state", 32'(bus.state), 32'd0);

        // Exact press latency: DEBOUNCE_CYCLES+3 edges.
        bus.key_n = 2'b01;
        exp_q.push_back(1);
        cyc(6);
        check("lat_before", 32'(bus.pos), 32'd0);
        cyc(1);
        check("lat_exact", 32'(bus.pos), 32'd1);
        check("lat_step_hi", 32'(bus.step), 32'd1);
        cyc(1);
        check("lat_step_lo", 32'(bus.step), 32'd0);
        cyc(12);
        bus.key_n = 2'b11;
        cyc(15);
        check("release_no_step", 32'(bus.pos), 32'd1);

        vecs[0]  = mk(2'b10, 10, 0, 0);
        vecs[1]  = mk(2'b11, 10, -1, 0);
        vecs[2]  = mk(2'b10, 3, -1, 0);
        vecs[3]  = mk(2'b11, 10, -1, 0);
        vecs[4]  = mk(2'b10, 10, 5, 5);
        vecs[5]  = mk(2'b11, 10, -1, 5);
        vecs[6]  = mk(2'b10, 10, 4, 4);
        vecs[7]  = mk(2'b11, 10, -1, 4);
        vecs[8]  = mk(2'b01, 10, 5, 5);
        vecs[9]  = mk(2'b11, 10, -1, 5);
        vecs[10] = mk(2'b01, 10, 0, 0);
        vecs[11] = mk(2'b11, 10, -1, 0);
        vecs[12] = mk(2'b01, 10, 1, 1);
        vecs[13] = mk(2'b11, 10, -1, 1);
        vecs[14] = mk(2'b01, 10, 2, 2);
        vecs[15] = mk(2'b11, 10, -1, 2);
        vecs[16] = mk(2'b01, 10, 3, 3);
        vecs[17] = mk(2'b11, 10, -1, 3);
        vecs[18] = mk(2'b00, 10, 0, 0);
        vecs[19] = mk(2'b11, 10, -1, 0);
        vecs[20] = mk(2'b01, 10, 1, 1);
        vecs[21] = mk(2'b11, 10, -1, 1);
        vecs[22] = mk(2'b01, 10, 2, 2);
        vecs[23] = mk(2'b11, 10, -1, 2);
        vecs[24] = mk(2'b01, 10, 3, 3);
        vecs[25] = mk(2'b11, 10, -1, 3);
        vecs[26] = mk(2'b01, 10, 4, 4);
        vecs[27] = mk(2'b11, 10, -1, 4);

        for (int i = 0; i < 28; i++) begin
            bus.key_n = vecs[i].key_n;
            if (vecs[i].push >= 0) exp_q.push_back(vecs[i].push);
            cyc(vecs[i].hold);
            check($sformatf("vec%0d_pos", i), 32'(bus.pos), 32'(vecs[i].pos));
            check($sformatf("vec%0d_state", i), 32'(bus.state), 32'd0);
        end
        check("manual_drained", 32'(exp_q.size()), 32'd0);

        // Auto from pos 4, then pause on a press that lands on a tick, then resume.
        bus.mode_sw = 1'b1;
        bus.dir_sw  = 1'b0;
        exp_q.push_back(5);
        exp_q.push_back(0);
        exp_q.push_back(1);
        cyc(2);
        check("auto_sync_wait", 32'(bus.state), 32'd0);
        cyc(1);
        check("auto_entry", 32'(bus.state), 32'd1);
        cyc(7);
        check("auto_pre_tick", 32'(bus.pos), 32'd4);
        cyc(1);
        check("auto_first", 32'(bus.pos), 32'd5);
        cyc(16);
        check("auto_third", 32'(bus.pos), 32'd1);
        cyc(1);
        bus.key_n = 2'b01;
        cyc(7);
        check("pause_state", 32'(bus.state), 32'd2);
        check("pause_no_tick", 32'(bus.pos), 32'd1);
        cyc(3);
        bus.key_n = 2'b11;
        cyc(40);
        check("paused_frozen_pos", 32'(bus.pos), 32'd1);
        check("paused_frozen_state", 32'(bus.state), 32'd2);
        bus.key_n = 2'b01;
        exp_q.push_back(2);
        cyc(7);
        check("resume_state", 32'(bus.state), 32'd1);
        check("resume_pos", 32'(bus.pos), 32'd1);
        cyc(3);
        bus.key_n = 2'b11;
        cyc(4);
        check("resume_pre_tick", 32'(bus.pos), 32'd1);
        cyc(1);
        check("resume_tick", 32'(bus.pos), 32'd2);

        // Mode drop while a right press is still debouncing: manual step, no pause.
        cyc(1);
        bus.key_n = 2'b10;
        cyc(3);
        bus.mode_sw = 1'b0;
        exp_q.push_back(1);
        cyc(3);
        check("mode_drop_state", 32'(bus.state), 32'd0);
        check("mode_drop_pos", 32'(bus.pos), 32'd2);
        cyc(1);
        check("late_key_manual", 32'(bus.pos), 32'd1);
        check("late_key_state", 32'(bus.state), 32'd0);
        cyc(3);
        bus.key_n = 2'b11;
        cyc(10);

        for (int i = 0; i < 3; i++) begin
            bus.key_n = 2'b01;
            exp_q.push_back(2 + i);
            cyc(10);
            bus.key_n = 2'b11;
            cyc(10);
        end
        check("pre_scroll_pos", 32'(bus.pos), 32'd4);

`ifdef SCROLL_BOUNCE_EN
        seq_a = '{5, 4, 3, 2, 1, 0, 1};
        seq_b = '{0, 1};
`else
        seq_a = '{5, 0, 1, 2};
        seq_b = '{1, 0};
`endif
        foreach (seq_a[i]) exp_q.push_back(seq_a[i]);
        run_auto(1'b0, seq_a.size());
        check("scroll_a_end", 32'(bus.pos), 32'(seq_a[seq_a.size() - 1]));
        foreach (seq_b[i]) exp_q.push_back(seq_b[i]);
        run_auto(1'b1, seq_b.size());
        check("scroll_b_end", 32'(bus.pos), 32'(seq_b[seq_b.size() - 1]));

        // Reset in the middle of a debounce restarts the full latency.
        bus.key_n = 2'b01;
        cyc(5);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("midreset_pos", 32'(bus.pos), 32'd0);
        check("midreset_state", 32'(bus.state), 32'd0);
        exp_q.push_back(1);
        cyc(6);
        check("midreset_discard", 32'(bus.pos), 32'd0);
        cyc(1);
        check("midreset_repress", 32'(bus.pos), 32'd1);
        bus.key_n = 2'b11;
        cyc(10);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
